multicycle_cpu_core: RTL and testbench
======================================

Name: multicycle_cpu_core

Overview:
- Parametrised multi-cycle CPU core: the next generation of the team's FSM-sequenced CPU.
- Data width, register count, PC width and data-address width are configurable.
- Instruction and data memories are external, behind req/ack handshakes, so wait-state memories can be attached.
- Adds branches, load/store with base+offset and a HALT state; sits between program memory and data memory at top level.

Parameters:
DATA_W, 16, datapath/register width (8..32)
NREGS, 16, number of general registers (2..16, power of two)
PC_W, 10, program counter / instruction address width
DADDR_W, 8, data memory address width

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DADDR_W  data address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  access complete; dmem_rdata valid on load
dmem_rdata  in  DATA_W  load data
state  out  3  current FSM state code
halted  out  1  core in HALT
dbg_out  out  DATA_W  last value written to register file

Behaviour:
- Reset (rst: synchronous, active-high; clk): pc=0, all registers=0, state=FETCH, dbg_out=0, halted=0, dmem_req=0, dmem_we=0; imem_req=1 the cycle after reset deasserts. Reset mid-handshake aborts it; req drops on the next edge, any late ack is ignored.
- Instruction fields: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0].
- Register indices use only the low log2(NREGS) bits of each field.
- imm is sign-extended or truncated to DATA_W.
- Opcodes:
  - 0: NOP
  - 1: ADD
  - 2: SUB
  - 3: AND
  - 4: OR
  - 5: XOR (rd = rs1 op rs2)
  - 6: ADDI (rd = rs1 + imm)
  - 7: LDI (rd = imm)
  - 8: MOV (rd = rs1)
  - 9: LD (rd = mem[rs1+imm])
  - 10: ST (mem[rs1+imm] = rs2)
  - 11: JMP (pc = imm[PC_W-1:0])
  - 12: BEQZ (if rs1 == 0, pc = imm)
  - 13: MUL, see Optional Feature
  - 14: undefined, treated as NOP
  - 15: HALT
- Arithmetic wraps modulo 2^DATA_W; no flags.
- Data address = low DADDR_W bits of (rs1 + imm).
- States (state code in parentheses):
  - FETCH (0): imem_req=1 until imem_ack; on ack latch imem_data, pc <= pc+1 (wraps), go DECODE.
  - DECODE (1): latch operands from register file, go EXEC.
  - EXEC (2): compute result/address.
    - JMP, BEQZ-taken: load pc.
    - LD, ST: go MEM.
    - HALT: go HALT.
    - All others: go WB.
  - MEM (3): dmem_req=1 with stable addr/we/wdata until dmem_ack; LD latches rdata; go WB. dmem_req drops the cycle after ack.
  - WB (4): write rd for opcodes 1-9 (and 13 when enabled); dbg_out <= written value; go FETCH.
  - HALT (5): halted=1; no requests; leaves only via rst.
- Latency: with single-cycle ack, ALU/LDI/MOV take 4 cycles; LD and ST take 5; JMP/BEQZ take 4 (pass through WB, no write); NOP takes 4.
- Acks arriving when the matching req is low are ignored.
- Register source equal to destination reads the old value.

Optional Feature:
- Macro MULT_EN.
- Defined: opcode 13 = MUL, rd = low DATA_W bits of rs1*rs2, latency as ALU.
- Undefined: opcode 13 is a NOP with no register write; no multiplier is inferred.

Test Plan:
- LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT, 1-cycle ack -> r3=12, dbg_out=12, halted=1; ADD takes exactly 4 cycles from imem_req to next imem_req.
- SUB r3,r1,r2 with r1=0, r2=1, DATA_W=16 -> r3=0xFFFF (wrap).
- ST r2 to [r1+3] with r1=5, r2=0xABCD, then LD r4,[r1+3]; dmem_ack delayed 3 cycles -> dmem_addr=8 held stable with req high throughout; r4=0xABCD.
- BEQZ r0,imm=20 with r0=0 -> next imem_addr=20; repeat with r0=1 -> next imem_addr=pc+1.
- rst asserted during MEM wait -> next cycle state=FETCH, pc=0, registers 0, dmem_req=0; late dmem_ack is ignored.
- MUL r3,r1,r2 with r1=300, r2=300 -> with MULT_EN: r3=0x5F90; without MULT_EN: r3 unchanged.

Source files
------------

// File: rtl/multicycle_cpu_core_if.sv
// Instruction and data memory handshake bundle for multicycle_cpu_core.
// The core drives the master side; memories (or a bench) take the slave side.
interface multicycle_cpu_core_if #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 10,
  parameter int DADDR_W = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_data;

  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_cpu_core.sv
// FSM-sequenced multi-cycle CPU core with req/ack instruction and data memories.
// Define MULT_EN to make opcode 13 a multiply; otherwise it behaves as a NOP.
module multicycle_cpu_core #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter int PC_W    = 10,
  parameter int DADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_cpu_core_if.master  bus,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [DATA_W-1:0]      dbg_out
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Opcodes 0 and 14 fall through to the default (no-write) path.
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_BEQZ = 4'd12;
`ifdef MULT_EN
  localparam logic [3:0] OP_MUL  = 4'd13;
`endif
  localparam logic [3:0] OP_HALT = 4'd15;

  logic [PC_W-1:0]    pc;
  logic [31:0]        ir;
  logic [DATA_W-1:0]  regs [NREGS];
  logic [DATA_W-1:0]  op_a, op_b, result;
  logic               wr_en;
  logic [DADDR_W-1:0] daddr_q;
  logic               dwe_q;
  logic [DATA_W-1:0]  dwdata_q;

  logic [3:0]         op;
  logic [RIDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]  imm_ext, addr_sum;
  logic [PC_W-1:0]    jmp_tgt;
  logic               branch_taken;

  assign op       = ir[31:28];
  assign rd_idx   = ir[24 +: RIDX_W];
  assign rs1_idx  = ir[20 +: RIDX_W];
  assign rs2_idx  = ir[16 +: RIDX_W];
  // Size casts sign-extend the immediate when DATA_W > 16 and truncate otherwise.
  assign imm_ext  = DATA_W'($signed(ir[15:0]));
  assign jmp_tgt  = PC_W'(ir[15:0]);
  assign addr_sum = op_a + imm_ext;
  assign branch_taken = (op == OP_JMP) || ((op == OP_BEQZ) && (op_a == '0));

  logic [DATA_W-1:0]  alu_res;
  logic               alu_wr;
  logic [2:0]         exec_next;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b0;
    exec_next = S_WB;
    case (op)
      OP_ADD:  begin alu_res = op_a + op_b; alu_wr = 1'b1; end
      OP_SUB:  begin alu_res = op_a - op_b; alu_wr = 1'b1; end
      OP_AND:  begin alu_res = op_a & op_b; alu_wr = 1'b1; end
      OP_OR:   begin alu_res = op_a | op_b; alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = op_a ^ op_b; alu_wr = 1'b1; end
      OP_ADDI: begin alu_res = addr_sum;    alu_wr = 1'b1; end
      OP_LDI:  begin alu_res = imm_ext;     alu_wr = 1'b1; end
      OP_MOV:  begin alu_res = op_a;        alu_wr = 1'b1; end
`ifdef MULT_EN
      OP_MUL:  begin alu_res = op_a * op_b; alu_wr = 1'b1; end
`endif
      OP_LD:   begin alu_wr = 1'b1; exec_next = S_MEM; end
      OP_ST:   exec_next = S_MEM;
      OP_HALT: exec_next = S_HALT;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      wr_en    <= 1'b0;
      daddr_q  <= '0;
      dwe_q    <= 1'b0;
      dwdata_q <= '0;
      dbg_out  <= '0;
      // NOTE: the register file must read zero after reset, so it is built from
      // resettable flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_ack) begin
          ir    <= bus.imem_data;
          pc    <= pc + PC_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          op_a  <= regs[rs1_idx];
          op_b  <= regs[rs2_idx];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result   <= alu_res;
          wr_en    <= alu_wr;
          daddr_q  <= DADDR_W'(addr_sum);
          dwe_q    <= (op == OP_ST);
          dwdata_q <= op_b;
          if (branch_taken) pc <= jmp_tgt;
          state <= exec_next;
        end
        S_MEM: if (bus.dmem_ack) begin
          if (!dwe_q) result <= bus.dmem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          if (wr_en) begin
            regs[rd_idx] <= result;
            dbg_out      <= result;
          end
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // The fetch request is held off while reset is asserted.
  assign bus.imem_req   = (state == S_FETCH) && !rst;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = dwe_q && (state == S_MEM);
  assign bus.dmem_addr  = daddr_q;
  assign bus.dmem_wdata = dwdata_q;
  assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: wait-state memory models and
// hand-computed expectations for ALU, load/store, branch, reset and MUL cases.
module tb_multicycle_cpu_core;
  localparam int DATA_W  = 16;
  localparam int NREGS   = 16;
  localparam int PC_W    = 10;
  localparam int DADDR_W = 8;
  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]        state;
  logic              halted;
  logic [DATA_W-1:0] dbg_out;

  multicycle_cpu_core_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W)) bus ();

  multicycle_cpu_core #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W), .DADDR_W(DADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .state   (state),
    .halted  (halted),
    .dbg_out (dbg_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [31:0] imem [1024];
  logic [15:0] dmem [256];
  int   i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
  logic force_dack = 1'b0;
  logic [7:0] exp_daddr = 8'd8;

  int          fa_q[$], fc_q[$];
  logic [15:0] dq[$];
  logic [15:0] dbg_prev = '0;
  int          mem_cyc = 0, mem_we_cyc = 0, mem_bad = 0;

  // Memory responders plus fetch/write/data-access loggers, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      fa_q.delete(); fc_q.delete(); dq.delete();
      dbg_prev = '0; mem_cyc = 0; mem_we_cyc = 0; mem_bad = 0;
    end else if (dbg_out != dbg_prev) begin
      dq.push_back(dbg_out);
      dbg_prev = dbg_out;
    end
    if (bus.imem_req && i_cnt >= i_wait) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = imem[bus.imem_addr];
      fa_q.push_back(int'(bus.imem_addr));
      fc_q.push_back(cyc);
      i_cnt = 0;
    end else begin
      bus.imem_ack = 1'b0;
      i_cnt = bus.imem_req ? i_cnt + 1 : 0;
    end
    if (state == 3'd3 && !bus.dmem_req) mem_bad++;
    if (bus.dmem_req) begin
      mem_cyc++;
      if (bus.dmem_we) mem_we_cyc++;
      if (bus.dmem_addr != exp_daddr) mem_bad++;
    end
    if (bus.dmem_req && d_cnt >= d_wait) begin
      bus.dmem_ack = 1'b1;
      if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
      else             bus.dmem_rdata = dmem[bus.dmem_addr];
      d_cnt = 0;
    end else begin
      bus.dmem_ack = force_dack;
      d_cnt = bus.dmem_req ? d_cnt + 1 : 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    check(tag, halted, 1'b1);
  endtask

  task automatic check_gap(input string tag, input int idx, input int exp);
    if (fc_q.size() > idx) check(tag, fc_q[idx] - fc_q[idx-1], exp);
    else                   check({tag, ".fetches"}, fc_q.size(), idx + 1);
  endtask

  task automatic check_dq(input string tag, input logic [15:0] e[$]);
    check({tag, ".writes"}, dq.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < dq.size()) check($sformatf("%s[%0d]", tag, i), dq[i], e[i]);
  endtask

  initial begin
    logic [15:0] e[$];
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] e[$];

    // Reset state, then LDI/LDI/ADD/HALT with single-cycle acks.
    clear_imem();
    imem[0] = ins(7, 1, 0, 0, 5);
    imem[1] = ins(7, 2, 0, 0, 7);
    imem[2] = ins(1, 3, 1, 2, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.state", state, 3'd0);
    check("rst.halted", halted, 1'b0);
    check("rst.dbg", dbg_out, 16'h0);
    check("rst.imem_req", bus.imem_req, 1'b0);
    check("rst.dmem_req", bus.dmem_req, 1'b0);
    check("rst.dmem_we", bus.dmem_we, 1'b0);
    check("rst.pc", bus.imem_addr, 10'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst.imem_req", bus.imem_req, 1'b1);
    wait_halt("add.halt", 100);
    check("add.dbg", dbg_out, 16'd12);
    check("add.state", state, 3'd5);
    check_gap("ldi.latency", 1, 4);
    check_gap("add.latency", 3, 4);
    repeat (3) @(negedge clk);
    check("halt.imem_req", bus.imem_req, 1'b0);
    check("halt.dmem_req", bus.dmem_req, 1'b0);
    check("halt.stays", halted, 1'b1);

    // SUB wraps modulo 2^16.
    clear_imem();
    imem[0] = ins(7, 1, 0, 0, 0);
    imem[1] = ins(7, 2, 0, 0, 1);
    imem[2] = ins(2, 3, 1, 2, 0);
    do_reset();
    wait_halt("sub.halt", 100);
    check("sub.wrap", dbg_out, 16'hFFFF);

    // Logic ops, negative ADDI, SUB, MOV, source==destination, LDI with bit 15 set.
    clear_imem();
    imem[0]  = ins(7, 1, 0, 0, 16'h00F0);
    imem[1]  = ins(7, 2, 0, 0, 16'h0FF0);
    imem[2]  = ins(3, 3, 1, 2, 0);
    imem[3]  = ins(4, 4, 1, 2, 0);
    imem[4]  = ins(5, 5, 1, 2, 0);
    imem[5]  = ins(6, 6, 5, 0, 16'hFFFF);
    imem[6]  = ins(2, 7, 2, 1, 0);
    imem[7]  = ins(8, 8, 6, 0, 0);
    imem[8]  = ins(1, 2, 2, 2, 0);
    imem[9]  = ins(7, 9, 0, 0, 16'h8000);
    do_reset();
    wait_halt("alu.halt", 200);
    e = '{16'h00F0, 16'h0FF0, 16'h00F0, 16'h0FF0, 16'h0F00,
          16'h0EFF, 16'h0F00, 16'h0EFF, 16'h1FE0, 16'h8000};
    check_dq("alu", e);

    // Store then load at r1+3 = 8; first with zero wait, then with 3 wait states.
    clear_imem();
    imem[0] = ins(7, 1, 0, 0, 5);
    imem[1] = ins(7, 2, 0, 0, 16'hABCD);
    imem[2] = ins(10, 0, 1, 2, 3);
    imem[3] = ins(7, 2, 0, 0, 0);
    imem[4] = ins(9, 4, 1, 0, 3);
    exp_daddr = 8'd8;
    for (int pass = 0; pass < 2; pass++) begin
      dmem[8] = 16'h0000;
      d_wait  = (pass == 0) ? 0 : 3;
      do_reset();
      wait_halt($sformatf("mem%0d.halt", pass), 200);
      check_gap($sformatf("mem%0d.st_latency", pass), 3, 5 + d_wait);
      check_gap($sformatf("mem%0d.ld_latency", pass), 5, 5 + d_wait);
      check($sformatf("mem%0d.stored", pass), dmem[8], 16'hABCD);
      check($sformatf("mem%0d.req_cycles", pass), mem_cyc, 2 * (d_wait + 1));
      check($sformatf("mem%0d.we_cycles", pass), mem_we_cyc, d_wait + 1);
      check($sformatf("mem%0d.addr_req_stable", pass), mem_bad, 0);
      e = '{16'h0005, 16'hABCD, 16'h0000, 16'hABCD};
      check_dq($sformatf("mem%0d", pass), e);
    end
    d_wait = 0;

    // BEQZ taken and not taken, then JMP.
    clear_imem();
    imem[0]  = ins(7, 0, 0, 0, 0);
    imem[1]  = ins(12, 0, 0, 0, 20);
    imem[20] = ins(7, 0, 0, 0, 1);
    imem[21] = ins(12, 0, 0, 0, 40);
    imem[22] = ins(11, 0, 0, 0, 50);
    do_reset();
    wait_halt("br.halt", 200);
    e = '{16'd0, 16'd1, 16'd20, 16'd21, 16'd22, 16'd50};
    check("br.fetches", fa_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < fa_q.size()) check($sformatf("br.addr[%0d]", i), fa_q[i], e[i]);
    check_gap("beqz.latency", 2, 4);

    // Reset during a stalled store; late dmem_ack must be ignored.
    clear_imem();
    imem[0] = ins(7, 1, 0, 0, 9);
    imem[1] = ins(7, 2, 0, 0, 3);
    imem[2] = ins(10, 0, 1, 2, 0);
    dmem[9] = 16'h1234;
    d_wait  = 1000;
    do_reset();
    begin
      int n = 0;
      while (state != 3'd3 && n < 100) begin @(negedge clk); n++; end
      check("rstmem.reach_mem", state, 3'd3);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rstmem.imem_req_in_rst", bus.imem_req, 1'b0);
    @(posedge clk); #1;
    check("rstmem.state", state, 3'd0);
    check("rstmem.pc", bus.imem_addr, 10'd0);
    check("rstmem.dmem_req", bus.dmem_req, 1'b0);
    check("rstmem.dbg", dbg_out, 16'h0);
    i_wait = 1000; force_dack = 1'b1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack.state", state, 3'd0);
      check("late_ack.dmem_req", bus.dmem_req, 1'b0);
    end
    @(posedge clk); #1;
    force_dack = 1'b0; d_wait = 0;
    imem[0] = ins(6, 5, 1, 0, 1);
    imem[1] = ins(6, 6, 2, 0, 2);
    imem[2] = HALT_W;
    i_wait = 0;
    wait_halt("rstmem.halt", 200);
    e = '{16'h0001, 16'h0002};
    check_dq("rstmem.regs_zero", e);
    check("rstmem.no_store", dmem[9], 16'h1234);

    // Opcode 13 (MUL when enabled), undefined opcode 14 and NOP targeting r3.
    clear_imem();
    imem[0] = ins(7, 1, 0, 0, 300);
    imem[1] = ins(7, 2, 0, 0, 300);
    imem[2] = ins(7, 3, 0, 0, 16'h1111);
    imem[3] = ins(13, 3, 1, 2, 0);
    imem[4] = ins(14, 3, 1, 2, 16'h7777);
    imem[5] = ins(0, 3, 0, 0, 5);
    imem[6] = ins(8, 4, 3, 0, 0);
    do_reset();
    wait_halt("mul.halt", 200);
`ifdef MULT_EN
    check("mul.r3", dbg_out, 16'h5F90);
`else
    check("mul.r3", dbg_out, 16'h1111);
`endif
    check_gap("mul.latency", 4, 4);
    check_gap("undef.latency", 5, 4);
    check_gap("nop.latency", 6, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
